// File: rtl/mcpu_ctrl_fsm_pkg.sv
// Shared definitions for the MCPU multicycle controller: state encodings,
// opcode constants, datapath select codes, the control-word payload and the
// state-to-control decode.
package mcpu_ctrl_fsm_pkg;

    localparam int unsigned ST_W  = 4;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Control word driven to the datapath; one flop per field.
    typedef struct packed {
        logic             pc_write;
        logic             branch;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             mem_to_reg;
        logic             reg_dst;
        logic             reg_write;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_source;
    } ctrl_t;

    // States that access memory and may be stretched by the stall counter.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // Control word for a state; mem_last marks the final cycle of a stalled
    // access, which gates the IR and PC loads in FETCH.
    function automatic ctrl_t decode_ctrl(input state_e s, input logic mem_last);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCSRC_ALU;
                c.ir_write  = mem_last;
                c.pc_write  = mem_last;
            end
            S_DECODE: c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_SUB;
                c.branch    = 1'b1;
                c.pc_source = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mcpu_ctrl_fsm_if.sv
// Controller <-> datapath bundle.
//   op        : IR[31:26] from the datapath
//   pc_write .. pc_source : control word to the datapath
//   illegal_op: one-cycle flag for an unsupported opcode
//   state_o   : current controller state (debug)
// master = controller side, slave = datapath side.
interface mcpu_ctrl_fsm_if
    import mcpu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned STATE_W = 4
);
    logic [OP_W-1:0]    op;
    logic               pc_write;
    logic               branch;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   alu_op;
    logic [SEL_W-1:0]   pc_source;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  op,
        output pc_write, branch, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, state_o
    );

    modport slave (
        output op,
        input  pc_write, branch, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, state_o
    );
endinterface

// File: rtl/mcpu_ctrl_fsm_wait_ctr.sv
// Memory stall counter: counts 0..MEM_WAIT while a memory state is active.
//   clk, rst_n  : clock, async active-low reset
//   start       : current state is a memory-access state
//   done        : current cycle is the final cycle of that access
//   done_next_c : the next cycle would be a final cycle if it is spent in a
//                 memory state (lets the controller register its outputs)
module mcpu_wait_ctr #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done,
    output logic done_next_c
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             running;

    assign done    = start && (cnt_q == LAST);
    assign running = start && !done;

    // Advance while stalled, otherwise clear so every access starts at 0.
    always_comb begin
        cnt_d = '0;
        if (running) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Staying in the access: next count decides; entering a fresh one: count 0.
    assign done_next_c = running ? (cnt_d == LAST) : (LAST == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multicycle control unit for the MCPU datapath. Sequences FETCH..WRITEBACK
// from the IR opcode. Every output is a flop loaded from the decode of the
// next state, so reg_write is glitch-free toward the level-sensitive RF.
//   clk, rst_n : clock, async active-low reset
//   bus        : master side of mcpu_ctrl_fsm_if (op in, control word out)
module mcpu_ctrl_fsm
    import mcpu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned STATE_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mcpu_ctrl_fsm_if.master bus
);
    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    logic   illegal_q;
    logic   illegal_d;

    logic   mem_busy;
    logic   mem_last;
    logic   mem_last_next;

    assign mem_busy = is_mem_state(state_q);

    mcpu_wait_ctr #(
        .MEM_WAIT(MEM_WAIT)
    ) u_wait_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (mem_busy),
        .done       (mem_last),
        .done_next_c(mem_last_next)
    );

    // State, control word and illegal flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state plus the control word for the state being entered.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = '0;
        illegal_d = 1'b0;

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_last) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // Only a store goes to the write path; anything else reads.
            S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_last) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_last) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase

        ctrl_d = decode_ctrl(state_d, is_mem_state(state_d) && mem_last_next);
    end

    assign bus.pc_write   = ctrl_q.pc_write;
    assign bus.branch     = ctrl_q.branch;
    assign bus.iord       = ctrl_q.iord;
    assign bus.mem_read   = ctrl_q.mem_read;
    assign bus.mem_write  = ctrl_q.mem_write;
    assign bus.ir_write   = ctrl_q.ir_write;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.reg_write  = ctrl_q.reg_write;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.pc_source  = ctrl_q.pc_source;
    assign bus.illegal_op = illegal_q;
    assign bus.state_o    = STATE_W'(state_q);
endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: two instances (MEM_WAIT=0 and 2) run the same
// program; an instruction-level model builds the per-cycle control stream.
module tb_mcpu_ctrl_fsm;
    localparam int W0 = 0;
    localparam int W1 = 2;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JUNK = 6'b111111;

    localparam logic [3:0] ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MEMADR = 4'd3,
                           ST_MEMRD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWR = 4'd6,
                           ST_EXEC = 4'd7, ST_RWB = 4'd8, ST_BRANCH = 4'd9,
                           ST_ADDIEX = 4'd10, ST_ADDIWB = 4'd11, ST_JUMP = 4'd12;

    localparam logic [5:0] PROG [8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_JUNK, OP_R};

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic [3:0] state;
    } obs_t;

    typedef struct packed {
        obs_t       e;
        logic [5:0] op;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcpu_ctrl_fsm_if #(.STATE_W(4)) bus0 ();
    mcpu_ctrl_fsm_if #(.STATE_W(4)) bus1 ();

    mcpu_ctrl_fsm #(.MEM_WAIT(W0), .STATE_W(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mcpu_ctrl_fsm #(.MEM_WAIT(W1), .STATE_W(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    obs_t obs0, obs1;
    assign obs0 = {bus0.pc_write, bus0.branch, bus0.iord, bus0.mem_read, bus0.mem_write,
                   bus0.ir_write, bus0.mem_to_reg, bus0.reg_dst, bus0.reg_write, bus0.alu_src_a,
                   bus0.alu_src_b, bus0.alu_op, bus0.pc_source, bus0.illegal_op, bus0.state_o};
    assign obs1 = {bus1.pc_write, bus1.branch, bus1.iord, bus1.mem_read, bus1.mem_write,
                   bus1.ir_write, bus1.mem_to_reg, bus1.reg_dst, bus1.reg_write, bus1.alu_src_a,
                   bus1.alu_src_b, bus1.alu_op, bus1.pc_source, bus1.illegal_op, bus1.state_o};

    int    total = 0;
    int    bad   = 0;
    step_t exp0[$];
    step_t exp1[$];
    logic  pend_ill [2];
    int    rwcnt [2];
    int    mwcnt [2];
    logic  prev_rw [2];
    logic  glitch_seen = 1'b0;

    // reg_write may only move on a rising clock edge or while reset is low.
    always @(obs0.reg_write or obs1.reg_write) begin
        if ($time > 0 && rst_n && ($time % 10) != 5) glitch_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
        end
    endtask

    function automatic obs_t get_obs(input int i);
        return (i == 0) ? obs0 : obs1;
    endfunction

    task automatic drive_op(input int i, input logic [5:0] v);
        if (i == 0) bus0.op = v;
        else        bus1.op = v;
    endtask

    task automatic push(input int i, input obs_t e, input logic [5:0] opd);
        step_t s;
        s.e  = e;
        s.op = opd;
        if (i == 0) exp0.push_back(s);
        else        exp1.push_back(s);
    endtask

    // Appends the cycles of one instruction; op is meaningful only in DECODE
    // and MEMADR, every other cycle gets junk to prove it is ignored.
    task automatic add_instr(input int i, input logic [5:0] opc);
        int   w;
        obs_t e;
        w = (i == 0) ? W0 : W1;
        for (int c = 0; c <= w; c++) begin
            e = '0;
            e.state      = ST_FETCH;
            e.mem_read   = 1'b1;
            e.alu_src_b  = 2'b01;
            e.ir_write   = (c == w);
            e.pc_write   = (c == w);
            e.illegal_op = pend_ill[i] && (c == 0);
            push(i, e, OP_JUNK);
        end
        pend_ill[i] = 1'b0;
        e = '0; e.state = ST_DECODE; e.alu_src_b = 2'b11;
        push(i, e, opc);
        case (opc)
            OP_LW, OP_SW: begin
                e = '0; e.state = ST_MEMADR; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                push(i, e, opc);
                for (int c = 0; c <= w; c++) begin
                    e = '0;
                    e.iord = 1'b1;
                    if (opc == OP_LW) begin e.state = ST_MEMRD; e.mem_read = 1'b1; end
                    else begin e.state = ST_MEMWR; e.mem_write = 1'b1; end
                    push(i, e, OP_JUNK);
                end
                if (opc == OP_LW) begin
                    e = '0; e.state = ST_MEMWB; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    push(i, e, OP_JUNK);
                end
            end
            OP_R: begin
                e = '0; e.state = ST_EXEC; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
                push(i, e, OP_JUNK);
                e = '0; e.state = ST_RWB; e.reg_write = 1'b1; e.reg_dst = 1'b1;
                push(i, e, OP_JUNK);
            end
            OP_BEQ: begin
                e = '0; e.state = ST_BRANCH; e.alu_src_a = 1'b1; e.alu_op = 2'b01;
                e.branch = 1'b1; e.pc_source = 2'b01;
                push(i, e, OP_JUNK);
            end
            OP_J: begin
                e = '0; e.state = ST_JUMP; e.pc_write = 1'b1; e.pc_source = 2'b10;
                push(i, e, OP_JUNK);
            end
            OP_ADDI: begin
                e = '0; e.state = ST_ADDIEX; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                push(i, e, OP_JUNK);
                e = '0; e.state = ST_ADDIWB; e.reg_write = 1'b1;
                push(i, e, OP_JUNK);
            end
            default: pend_ill[i] = 1'b1;
        endcase
    endtask

    // Per-cycle compare against the model plus the write-enable invariants.
    task automatic step_check(input int i, input int k);
        obs_t  o;
        step_t s;
        int    len;
        o   = get_obs(i);
        len = (i == 0) ? exp0.size() : exp1.size();
        if (k < len) begin
            s = (i == 0) ? exp0[k] : exp1[k];
            chk($sformatf("ctrl_i%0d_c%0d", i, k), 32'(o), 32'(s.e));
            if (o.reg_write) rwcnt[i]++;
            if (o.mem_write) mwcnt[i]++;
            drive_op(i, s.op);
        end else begin
            drive_op(i, OP_R);
        end
        chk($sformatf("rw_with_mw_i%0d_c%0d", i, k), 32'(o.reg_write & o.mem_write), 32'(0));
        chk($sformatf("rw_with_ir_i%0d_c%0d", i, k), 32'(o.reg_write & o.ir_write), 32'(0));
        chk($sformatf("rw_wide_i%0d_c%0d", i, k), 32'(o.reg_write & prev_rw[i]), 32'(0));
        prev_rw[i] = o.reg_write;
    endtask

    initial begin
        int   n;
        logic found;
        bus0.op = OP_JUNK;
        bus1.op = OP_JUNK;
        for (int i = 0; i < 2; i++) begin
            pend_ill[i] = 1'b0;
            rwcnt[i]    = 0;
            mwcnt[i]    = 0;
            prev_rw[i]  = 1'b0;
            for (int p = 0; p < 8; p++) add_instr(i, PROG[p]);
        end

        // Hand-derived pins on the model: program length and an RWB cycle.
        chk("model_len_w0", 32'(exp0.size()), 32'd29);
        chk("model_len_w2", 32'(exp1.size()), 32'd49);
        chk("model_rwb_w0", 32'({exp0[3].e.reg_write, exp0[3].e.reg_dst, exp0[3].e.state}), 32'({1'b1, 1'b1, 4'd8}));

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        chk("reset_i0", 32'(obs0), 32'(0));
        chk("reset_i1", 32'(obs1), 32'(0));
        rst_n = 1'b1;

        n = (exp0.size() > exp1.size()) ? exp0.size() : exp1.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            step_check(0, k);
            step_check(1, k);
            if (k == 0) begin
                chk("first_fetch_i0", 32'({obs0.state, obs0.mem_read, obs0.ir_write, obs0.pc_write}), 32'({4'd1, 3'b111}));
                chk("first_fetch_i1", 32'({obs1.state, obs1.mem_read, obs1.ir_write, obs1.pc_write}), 32'({4'd1, 3'b100}));
            end
            if (k == 3) chk("r_rwb_i0", 32'({obs0.state, obs0.reg_write, obs0.reg_dst}), 32'({4'd8, 2'b11}));
            if (k == 4) chk("r_back_fetch_i0", 32'(obs0.state), 32'd1);
            if (k == 15) chk("beq_i0", 32'({obs0.state, obs0.branch, obs0.alu_op, obs0.pc_source}), 32'({4'd9, 1'b1, 2'b01, 2'b01}));
            if (k == 18) chk("j_i0", 32'({obs0.state, obs0.pc_write, obs0.pc_source}), 32'({4'd12, 1'b1, 2'b10}));
            if (k == 25) chk("illegal_pulse_i0", 32'(obs0.illegal_op), 32'd1);
            if (k == 26) chk("illegal_end_i0", 32'(obs0.illegal_op), 32'd0);
            if (k >= 11 && k <= 13) chk($sformatf("lw_memrd_i1_c%0d", k), 32'({obs1.state, obs1.mem_read, obs1.iord}), 32'({4'd4, 2'b11}));
            if (k == 14) chk("lw_memwb_i1", 32'({obs1.state, obs1.reg_write, obs1.mem_to_reg}), 32'({4'd5, 2'b11}));
        end

        chk("rw_count_i0", 32'(rwcnt[0]), 32'd4);
        chk("rw_count_i1", 32'(rwcnt[1]), 32'd4);
        chk("mw_count_i0", 32'(mwcnt[0]), 32'd1);
        chk("mw_count_i1", 32'(mwcnt[1]), 32'd3);

        // Reset in the middle of an R-type writeback (instance 0 loops on R).
        found = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (obs0.state == ST_RWB) begin
                found = 1'b1;
                break;
            end
        end
        chk("rwb_reached", 32'(found), 32'd1);
        chk("rwb_write_hi", 32'(obs0.reg_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_i0", 32'(obs0), 32'(0));
        chk("async_rst_i1", 32'(obs1), 32'(0));
        repeat (2) @(negedge clk);
        chk("rst_idle_i0", 32'(obs0.state), 32'd0);
        chk("rst_idle_i1", 32'(obs1.state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_fetch_i0", 32'({obs0.state, obs0.mem_read, obs0.ir_write, obs0.pc_write, obs0.reg_write}), 32'({4'd1, 4'b1110}));
        chk("rst_fetch_i1", 32'({obs1.state, obs1.mem_read, obs1.ir_write, obs1.pc_write, obs1.reg_write}), 32'({4'd1, 4'b1000}));
        chk("rw_glitch_free", 32'(glitch_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
